// File: rtl/add42_uart_tx.sv
// add42_uart_tx: serial result transmitter for the add-42 project.
// Accepts a byte over valid/ready, adds ADD_OFFSET (mod 256) and sends the
// sum LSB first as a UART frame on the tx pin (idle high).
// Optional feature macro: PARITY_EN adds an even-parity bit after the data
// bits (11-bit frame). Without it the frame is plain 8N1 (10 bits).
module add42_uart_tx #(
    parameter int CLKS_PER_BIT = 16,
    parameter int ADD_OFFSET   = 42
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       ena,
    input  logic       in_valid,
    input  logic [7:0] in_data,
    output logic       in_ready,
    output logic       tx,
    output logic       busy
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] LAST_CNT = CW'(CLKS_PER_BIT - 1);
    localparam logic [7:0]    OFFSET   = 8'(ADD_OFFSET);

`ifdef PARITY_EN
    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
`endif

    state_t        state;
    state_t        state_next;
    logic [CW-1:0] baud_cnt;
    logic [CW-1:0] baud_next;
    logic [2:0]    bit_idx;
    logic [2:0]    idx_next;
    logic [7:0]    shreg;
    logic [7:0]    shreg_next;
    logic          tx_next;
    logic          busy_next;
    logic          accept;
    logic          tick;

    assign in_ready = (state == IDLE) && ena;
    assign accept   = in_valid && in_ready;
    assign tick     = (baud_cnt == LAST_CNT);

    // State register; tx and busy are registered from next-state values so the line never glitches
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= '0;
            shreg    <= '0;
            tx       <= 1'b1;
            busy     <= 1'b0;
        end else begin
            state    <= state_next;
            baud_cnt <= baud_next;
            bit_idx  <= idx_next;
            shreg    <= shreg_next;
            tx       <= tx_next;
            busy     <= busy_next;
        end
    end

    // Next-state logic: baud counter paces every line bit, bit index walks the data bits
    always_comb begin
        state_next = state;
        baud_next  = tick ? '0 : baud_cnt + CW'(1);
        idx_next   = bit_idx;
        shreg_next = shreg;
        case (state)
            IDLE: begin
                baud_next = '0;
                idx_next  = '0;
                if (accept) begin
                    shreg_next = in_data + OFFSET;
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    state_next = DATA;
                    idx_next   = '0;
                end
            end
            DATA: begin
                if (tick) begin
                    if (bit_idx == 3'd7) begin
`ifdef PARITY_EN
                        state_next = PARITY;
`else
                        state_next = STOP;
`endif
                    end else begin
                        idx_next = bit_idx + 3'd1;
                    end
                end
            end
`ifdef PARITY_EN
            PARITY: begin
                if (tick) state_next = STOP;
            end
`endif
            STOP: begin
                if (tick) state_next = IDLE;
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

    // Output logic: line level and busy flag that the registers will take on the next edge
    always_comb begin
        tx_next   = 1'b1;
        busy_next = (state_next != IDLE);
        case (state_next)
            IDLE:    tx_next = 1'b1;
            START:   tx_next = 1'b0;
            DATA:    tx_next = shreg_next[idx_next];
`ifdef PARITY_EN
            PARITY:  tx_next = ^shreg_next;
`endif
            STOP:    tx_next = 1'b1;
            default: tx_next = 1'b1;
        endcase
    end

endmodule
